oam_level_sequencer: RTL and testbench



---
 rtl/oam_pkg.sv | 23 ++
 rtl/oam_pp_row.sv | 38 +++
 rtl/oam_level_sequencer.sv | 118 +++++++++++
 tb/tb_oam_level_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_pkg.sv
// Shared types and helpers for the OAM level sequencer.
package oam_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } oam_state_e;

  localparam int unsigned DEF_MANTISSA_WIDTH = 23;
  localparam int unsigned ACC_W = 2 * DEF_MANTISSA_WIDTH + 4;

  // Accumulator width for an m-bit mantissa.
  function automatic int unsigned acc_width(int unsigned m);
    return 2 * m + 4;
  endfunction

  // Left shift that aligns row j of an m-bit mantissa product.
  function automatic int unsigned row_shift(int unsigned m, int unsigned j);
    return m - 2 * j + 1;
  endfunction

endpackage

// File: rtl/oam_pp_row.sv
// Combinational partial-product row generator for one level j (1-based, x[1] is the MSB).
module oam_pp_row #(
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned LVL_W          = 4
) (
  input  logic [MANTISSA_WIDTH-1:0] x,
  input  logic [MANTISSA_WIDTH-1:0] y,
  input  logic [LVL_W-1:0]          j,
  output logic [MANTISSA_WIDTH-1:0] ppx,
  output logic [MANTISSA_WIDTH-1:0] ppy
);

  localparam int unsigned M = MANTISSA_WIDTH;

  logic [M-1:0] sel;
  logic [M-1:0] mask;
  logic         xj;
  logic         yj;

  // sel marks bit j (vector bit M-j); mask keeps the bits strictly below it.
  always_comb begin
    sel  = '0;
    mask = '0;
    xj   = 1'b0;
    yj   = 1'b0;
    ppx  = '0;
    ppy  = '0;
    if ((j != '0) && (32'(j) <= M)) begin
      sel  = M'(1) << (M - 32'(j));
      mask = sel - M'(1);
      xj   = |(x & sel);
      yj   = |(y & sel);
      ppx  = ((xj ? y : ~y) & mask) | ((xj ~^ yj) ? sel : '0);
      ppy  = (yj ? x : ~x) & mask;
    end
  end

endmodule

// File: rtl/oam_level_sequencer.sv
// Multi-cycle OAM L1 approximate mantissa multiplier: one partial-product row per cycle.
module oam_level_sequencer
  import oam_pkg::*;
#(
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned MAX_LEVEL      = 9,
  parameter int unsigned LVL_W          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MANTISSA_WIDTH-1:0]     in_x,
  input  logic [MANTISSA_WIDTH-1:0]     in_y,
  input  logic [LVL_W-1:0]              in_level,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*MANTISSA_WIDTH+3:0]   out_acc,
  output logic [LVL_W-1:0]              out_level,
  output logic                          busy
);

  localparam int unsigned M    = MANTISSA_WIDTH;
  localparam int unsigned AccW = 2 * MANTISSA_WIDTH + 4;

  // Rows beyond (M+1)/2 would need a negative alignment shift.
  if ((MAX_LEVEL > (MANTISSA_WIDTH + 1) / 2) || ((1 << LVL_W) <= MAX_LEVEL)) begin : g_param_check
    $error("oam_level_sequencer: MAX_LEVEL/LVL_W out of range");
  end

  oam_state_e      state_q, state_d;
  logic [M-1:0]    x_q, x_d;
  logic [M-1:0]    y_q, y_d;
  logic [LVL_W-1:0] n_q, n_d;
  logic [LVL_W-1:0] j_q, j_d;
  logic [AccW-1:0] acc_q, acc_d;

  logic [M-1:0]     ppx;
  logic [M-1:0]     ppy;
  logic [AccW-1:0]  row_sum;
  logic [LVL_W-1:0] lvl_clamped;

  oam_pp_row #(
    .MANTISSA_WIDTH (M),
    .LVL_W          (LVL_W)
  ) u_pp_row (
    .x   (x_q),
    .y   (y_q),
    .j   (j_q),
    .ppx (ppx),
    .ppy (ppy)
  );

  assign row_sum     = AccW'(ppx) + AccW'(ppy);
  assign lvl_clamped = (32'(in_level) > MAX_LEVEL) ? LVL_W'(MAX_LEVEL) : in_level;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_acc   = acc_q;
  assign out_level = n_q;

  // Next-state, operand capture and row accumulation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    j_d     = j_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          n_d     = lvl_clamped;
          j_d     = LVL_W'(1);
          acc_d   = '0;
          state_d = (lvl_clamped == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + (row_sum << row_shift(M, 32'(j_q)));
        if (j_q == n_q) begin
          state_d = StDone;
        end else begin
          j_d = j_q + LVL_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_oam_level_sequencer.sv
// Scoreboard bench for oam_level_sequencer at M=8, MAX_LEVEL=4.
module tb_oam_level_sequencer;

  localparam int unsigned M  = 8;
  localparam int unsigned ML = 4;
  localparam int unsigned LW = 4;
  localparam int unsigned AW = 2 * M + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [M-1:0]  in_x = '0;
  logic [M-1:0]  in_y = '0;
  logic [LW-1:0] in_level = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_acc;
  logic [LW-1:0] out_level;
  logic          busy;

  oam_level_sequencer #(
    .MANTISSA_WIDTH (M),
    .MAX_LEVEL      (ML),
    .LVL_W          (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_level  (in_level),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_level (out_level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] acc;
    logic [LW-1:0] lvl;
    int            vcyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  bit   seen_head = 1'b0;

  logic [M-1:0]  rx, ry;
  logic [LW-1:0] rl;
  int            w;

  task automatic check(input string name, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: sum over rows j=1..n of (PPX_j + PPY_j) * 2^(M-2j+1), bits 1-based from the MSB.
  function automatic longint model(int unsigned x, int unsigned y, int unsigned lvl);
    longint      acc = 0;
    int unsigned n   = (lvl > ML) ? ML : lvl;
    for (int j = 1; j <= int'(n); j++) begin
      int unsigned full = 1 << (M - j);
      int unsigned xj   = (x >> (M - j)) & 1;
      int unsigned yj   = (y >> (M - j)) & 1;
      int unsigned lowx = x % full;
      int unsigned lowy = y % full;
      int unsigned ppx  = ((xj == yj) ? full : 0) + (xj != 0 ? lowy : full - 1 - lowy);
      int unsigned ppy  = (yj != 0) ? lowx : full - 1 - lowx;
      acc += longint'(ppx + ppy) * (longint'(1) << (M - 2 * j + 1));
    end
    return acc;
  endfunction

  // Presents a request and pushes its expectation once the handshake is seen; in_valid stays high.
  task automatic send(input logic [M-1:0] x, input logic [M-1:0] y, input logic [LW-1:0] lvl,
                      input longint want, output int waits);
    exp_t e;
    int   n;
    @(negedge clk);
    in_x     = x;
    in_y     = y;
    in_level = lvl;
    in_valid = 1'b1;
    waits    = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (in_ready) begin
        n      = (lvl > ML) ? ML : int'(lvl);
        e.acc  = AW'(want);
        e.lvl  = LW'(n);
        e.vcyc = cyc + n + 1;
        sb_q.push_back(e);
        return;
      end
      @(negedge clk);
      waits++;
    end
    check("accept_timeout", waits, 0);
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && !busy) return;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid) begin
        if (sb_q.size() == 0) begin
          check("result_expected", sb_q.size(), 1);
        end else begin
          mon_e = sb_q[0];
          if (!seen_head) begin
            check("latency", cyc, mon_e.vcyc);
            seen_head = 1'b1;
          end
          check("out_acc", out_acc, mon_e.acc);
          check("out_level", out_level, mon_e.lvl);
          check("in_ready_in_done", in_ready, 0);
          check("busy_in_done", busy, 1);
          if (out_ready) begin
            void'(sb_q.pop_front());
            seen_head = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request pending: reset must win.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_x     = 8'h5a;
    in_level = 4'd2;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_level", out_level, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    ready_mode = 0;

    // Directed rows.
    send(8'h80, 8'h80, 4'd1, 16384, w);
    drop();
    wait_idle();
    send(8'h00, 8'h00, 4'd2, 54976, w);
    drop();
    wait_idle();

    // Level 0 and clamped level.
    rx = M'($urandom);
    ry = M'($urandom);
    send(rx, ry, 4'd0, 0, w);
    drop();
    wait_idle();
    send(rx, ry, 4'd15, model(rx, ry, 4), w);
    drop();
    wait_idle();

    // Back-pressure held in DONE for 10 cycles.
    ready_mode = 2;
    rx = M'($urandom);
    ry = M'($urandom);
    send(rx, ry, 4'd3, model(rx, ry, 3), w);
    drop();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) break;
    end
    check("stall_reached_done", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    ready_mode = 0;
    rx = M'($urandom);
    ry = M'($urandom);
    send(rx, ry, 4'd2, model(rx, ry, 2), w);
    check("accept_after_handshake", w, 1);
    drop();
    wait_idle();

    // Reset during RUN of a level-4 request, with in_valid also high.
    rx = M'($urandom);
    ry = M'($urandom);
    send(rx, ry, 4'd4, model(rx, ry, 4), w);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    sb_q.delete();
    seen_head = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_acc", out_acc, 0);
    rx = M'($urandom);
    ry = M'($urandom);
    send(rx, ry, 4'd3, model(rx, ry, 3), w);
    drop();
    wait_idle();

    // Random traffic with random back-pressure; inputs change while the DUT runs.
    ready_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      rx = M'($urandom);
      ry = M'($urandom);
      rl = LW'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) rl = LW'($urandom_range(0, 15));
      send(rx, ry, rl, model(rx, ry, rl), w);
    end
    drop();
    wait_idle();
    ready_mode = 0;
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
